// File: rtl/sid_cmd_pkg.sv
// -----------------------------------------------------------------------------
// sid_cmd_pkg
// Shared constants and FSM state type for the UART-to-SID command sequencer.
//   SYNC_BYTE / ACK_BYTE / NAK_BYTE : framing and reply bytes
//   OP_WRITE / OP_PING / OP_READ    : opcodes carried in CMD[7:5]
//   state_e                         : sequencer FSM states
// Optional feature macro: SID_CMD_READBACK_EN (adds the REPLY2 state).
// -----------------------------------------------------------------------------
package sid_cmd_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] ACK_BYTE  = 8'h06;
  localparam logic [7:0] NAK_BYTE  = 8'h15;

  localparam logic [2:0] OP_WRITE = 3'b000;
  localparam logic [2:0] OP_PING  = 3'b001;
  localparam logic [2:0] OP_READ  = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_CMD,
    ST_GET_DATA,
    ST_GET_SUM,
    ST_ISSUE,
    ST_REPLY
`ifdef SID_CMD_READBACK_EN
    , ST_REPLY2
`endif
  } state_e;

endpackage

// File: rtl/sid_shadow_regs.sv
// -----------------------------------------------------------------------------
// sid_shadow_regs
// 32x8 shadow copy of the SID register file so written values can be read back.
//   clk, rst    : clock, asynchronous active-high reset
//   we_i        : write enable
//   waddr_i     : write address
//   wdata_i     : write data
//   raddr_i     : asynchronous read address
//   rdata_o     : read data (combinational)
// Used only when SID_CMD_READBACK_EN is defined.
// -----------------------------------------------------------------------------
module sid_shadow_regs (
  input  logic       clk,
  input  logic       rst,
  input  logic       we_i,
  input  logic [4:0] waddr_i,
  input  logic [7:0] wdata_i,
  input  logic [4:0] raddr_i,
  output logic [7:0] rdata_o
);

  logic [7:0] mem_q [32];

  // NOTE: this array is reset because a read of a never-written register must
  // return 0x00; that forces flops instead of a RAM macro, acceptable at 32x8.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mem_q[i] <= 8'h00;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sid_uart_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// sid_uart_cmd_ctrl
// Assembles SYNC/CMD/DATA/SUM frames from UART bytes, issues SID register
// writes with a ready handshake and answers each frame with ACK or NAK.
// Bad checksums, bad opcodes, inter-byte timeouts and overruns are dropped and
// counted in a saturating error counter.
//   clk, rst            : clock, asynchronous active-high reset
//   rx_valid, rx_data   : received byte strobe and value
//   tx_busy             : transmitter busy (rises the cycle after tx_start)
//   tx_start, tx_data   : reply byte strobe and value
//   sid_we, sid_addr,
//   sid_wdata, sid_ready: SID write request, held until sid_ready
//   err_cnt             : saturating error count
// Optional feature macro: SID_CMD_READBACK_EN (opcode 010 reads a shadow copy).
// -----------------------------------------------------------------------------
module sid_uart_cmd_ctrl
  import sid_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYC = 50000,
  parameter int ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  input  logic             tx_busy,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  output logic             sid_we,
  output logic [4:0]       sid_addr,
  output logic [7:0]       sid_wdata,
  input  logic             sid_ready,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  state_e           state_q, state_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [7:0]       data_q, data_d;
  logic [7:0]       reply_q, reply_d;   // byte waiting in REPLY for the transmitter
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             tx_start_q, tx_start_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             sid_we_q, sid_we_d;
  logic [4:0]       sid_addr_q, sid_addr_d;
  logic [7:0]       sid_wdata_q, sid_wdata_d;
  logic [ERR_W-1:0] err_q, err_d;

  logic in_frame;
  logic tmo_hit;
  logic err_evt;
  logic nak;

`ifdef SID_CMD_READBACK_EN
  logic       rd_pend_q, rd_pend_d;     // a second (data) byte follows the ACK
  logic       busy_seen_q, busy_seen_d; // tx_busy has risen since the ACK
  logic [7:0] shadow_rdata;

  sid_shadow_regs u_shadow (
    .clk     (clk),
    .rst     (rst),
    .we_i    (sid_we_q && sid_ready),
    .waddr_i (sid_addr_q),
    .wdata_i (sid_wdata_q),
    .raddr_i (cmd_q[4:0]),
    .rdata_o (shadow_rdata)
  );
`endif

  assign in_frame = (state_q == ST_GET_CMD) || (state_q == ST_GET_DATA) ||
                    (state_q == ST_GET_SUM);
  assign tmo_hit  = (tmo_q == TMO_LAST);

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    data_d      = data_q;
    reply_d     = reply_q;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
    sid_we_d    = sid_we_q;
    sid_addr_d  = sid_addr_q;
    sid_wdata_d = sid_wdata_q;
    err_evt     = 1'b0;
    nak         = 1'b0;
`ifdef SID_CMD_READBACK_EN
    rd_pend_d   = rd_pend_q;
    busy_seen_d = busy_seen_q;
`endif

    // Inter-byte timer: cleared on each byte and on abort, idle outside a frame.
    if (in_frame && !(rx_valid || tmo_hit)) tmo_d = tmo_q + 1'b1;
    else                                    tmo_d = '0;

    case (state_q)
      ST_IDLE: begin
        if (rx_valid && rx_data == SYNC_BYTE) state_d = ST_GET_CMD;
      end

      // CMD and DATA accept any value, including 0xA5: no resync mid-frame.
      ST_GET_CMD: begin
        if (rx_valid) begin
          cmd_d   = rx_data;
          state_d = ST_GET_DATA;
        end
      end

      ST_GET_DATA: begin
        if (rx_valid) begin
          data_d  = rx_data;
          state_d = ST_GET_SUM;
        end
      end

      ST_GET_SUM: begin
        if (rx_valid) begin
          nak = 1'b1;
          if (rx_data == (cmd_q ^ data_q)) begin
            case (cmd_q[7:5])
              OP_WRITE: begin
                nak         = 1'b0;
                state_d     = ST_ISSUE;
                sid_we_d    = 1'b1;
                sid_addr_d  = cmd_q[4:0];
                sid_wdata_d = data_q;
              end
              OP_PING: begin
                nak     = 1'b0;
                state_d = ST_REPLY;
                reply_d = ACK_BYTE;
              end
`ifdef SID_CMD_READBACK_EN
              OP_READ: begin
                nak       = 1'b0;
                state_d   = ST_REPLY;
                reply_d   = ACK_BYTE;
                rd_pend_d = 1'b1;
              end
`endif
              default: ;
            endcase
          end
          // A NAK goes out on the very next cycle when the transmitter is free.
          if (nak) begin
            err_evt = 1'b1;
            reply_d = NAK_BYTE;
            if (!tx_busy) begin
              tx_start_d = 1'b1;
              tx_data_d  = NAK_BYTE;
              state_d    = ST_IDLE;
            end else begin
              state_d = ST_REPLY;
            end
          end
        end
      end

      ST_ISSUE: begin
        if (sid_ready) begin
          sid_we_d = 1'b0;
          reply_d  = ACK_BYTE;
          state_d  = ST_REPLY;
        end
      end

      ST_REPLY: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = reply_q;
          state_d    = ST_IDLE;
`ifdef SID_CMD_READBACK_EN
          if (rd_pend_q) begin
            rd_pend_d   = 1'b0;
            busy_seen_d = 1'b0;
            state_d     = ST_REPLY2;
          end
`endif
        end
      end

`ifdef SID_CMD_READBACK_EN
      // Wait for the ACK to occupy the transmitter and finish before byte two.
      ST_REPLY2: begin
        if (tx_busy) begin
          busy_seen_d = 1'b1;
        end else if (busy_seen_q) begin
          tx_start_d = 1'b1;
          tx_data_d  = shadow_rdata;
          state_d    = ST_IDLE;
        end
      end
`endif

      default: state_d = ST_IDLE;
    endcase

    if (in_frame && !rx_valid && tmo_hit) begin
      state_d = ST_IDLE;
      err_evt = 1'b1;
    end

    // Overrun: the byte is dropped and the state is left alone.
    if (rx_valid && !in_frame && state_q != ST_IDLE) err_evt = 1'b1;

    // All error sources funnel into err_evt, so one cycle counts at most once.
    err_d = err_q;
    if (err_evt && err_q != {ERR_W{1'b1}}) err_d = err_q + 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cmd_q       <= 8'h00;
      data_q      <= 8'h00;
      reply_q     <= 8'h00;
      tmo_q       <= '0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      sid_we_q    <= 1'b0;
      sid_addr_q  <= 5'h00;
      sid_wdata_q <= 8'h00;
      err_q       <= '0;
`ifdef SID_CMD_READBACK_EN
      rd_pend_q   <= 1'b0;
      busy_seen_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      data_q      <= data_d;
      reply_q     <= reply_d;
      tmo_q       <= tmo_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      sid_we_q    <= sid_we_d;
      sid_addr_q  <= sid_addr_d;
      sid_wdata_q <= sid_wdata_d;
      err_q       <= err_d;
`ifdef SID_CMD_READBACK_EN
      rd_pend_q   <= rd_pend_d;
      busy_seen_q <= busy_seen_d;
`endif
    end
  end

  assign tx_start  = tx_start_q;
  assign tx_data   = tx_data_q;
  assign sid_we    = sid_we_q;
  assign sid_addr  = sid_addr_q;
  assign sid_wdata = sid_wdata_q;
  assign err_cnt   = err_q;

endmodule

// File: tb/tb_sid_uart_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sid_uart_cmd_ctrl
// Directed bench for sid_uart_cmd_ctrl with a small transmitter model that
// holds tx_busy for six cycles after each tx_start. Expected values are hand
// computed. Readback expectations follow SID_CMD_READBACK_EN.
// -----------------------------------------------------------------------------
module tb_sid_uart_cmd_ctrl;

  localparam int TMO = 20;
  localparam int EW  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          tx_busy;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          sid_we;
  logic [4:0]    sid_addr;
  logic [7:0]    sid_wdata;
  logic          sid_ready = 1'b0;
  logic [EW-1:0] err_cnt;

  int         checks = 0;
  int         errors = 0;
  int         busy_cnt = 0;
  int         viol = 0;
  logic       prev_start = 1'b0;
  logic [7:0] tx_log[$];
  int         n0;
  int         exp_err;

  sid_uart_cmd_ctrl #(.TIMEOUT_CYC(TMO), .ERR_W(EW)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .tx_busy   (tx_busy),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .sid_we    (sid_we),
    .sid_addr  (sid_addr),
    .sid_wdata (sid_wdata),
    .sid_ready (sid_ready),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  // Transmitter model and protocol monitor.
  assign tx_busy = (busy_cnt != 0);
  always @(posedge clk) begin
    if (tx_start) begin
      tx_log.push_back(tx_data);
      if (tx_busy || prev_start) viol++;
    end
    prev_start <= tx_start;
    if (tx_start)          busy_cnt <= 6;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] d, input logic [7:0] s);
    send_byte(8'hA5);
    send_byte(c);
    send_byte(d);
    send_byte(s);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_tx_start"}, tx_start, 1'b0);
    check({tag, "_tx_data"}, tx_data, 8'h00);
    check({tag, "_sid_we"}, sid_we, 1'b0);
    check({tag, "_sid_addr"}, sid_addr, 5'h00);
    check({tag, "_sid_wdata"}, sid_wdata, 8'h00);
    check({tag, "_err_cnt"}, err_cnt, 0);
  endtask

  task automatic wait_tx(input int n, input int budget);
    for (int i = 0; i < budget && tx_log.size() < n; i++) @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Reset values
    idle(2);
    check_reset_vals("reset");
    rst = 1'b0;
    idle(2);
    exp_err = 0;

    // Write with sid_ready held low for 4 cycles
    send_frame(8'h05, 8'h3C, 8'h39);
    check("wr_we_1cyc", sid_we, 1'b1);
    check("wr_addr", sid_addr, 5'h05);
    check("wr_wdata", sid_wdata, 8'h3C);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("wr_hold", {sid_we, sid_addr, sid_wdata, tx_start}, {1'b1, 5'h05, 8'h3C, 1'b0});
    end
    sid_ready = 1'b1;
    @(negedge clk);
    sid_ready = 1'b0;
    check("wr_we_drop", sid_we, 1'b0);
    check("wr_no_early_start", tx_start, 1'b0);
    @(negedge clk);
    check("wr_tx_start", tx_start, 1'b1);
    check("wr_tx_ack", tx_data, 8'h06);
    idle(10);
    check("wr_tx_count", tx_log.size(), 1);

    // Bad checksum: NAK one cycle after the SUM byte
    send_frame(8'h05, 8'h3C, 8'h00);
    exp_err++;
    check("bad_sum_start", tx_start, 1'b1);
    check("bad_sum_nak", tx_data, 8'h15);
    check("bad_sum_no_we", sid_we, 1'b0);
    check("bad_sum_err", err_cnt, exp_err);
    idle(10);

    // Timeout after SYNC+CMD, exact boundary
    n0 = tx_log.size();
    send_byte(8'hA5);
    send_byte(8'h05);
    idle(TMO - 1);
    check("tmo_not_yet", err_cnt, exp_err);
    idle(1);
    exp_err++;
    check("tmo_err", err_cnt, exp_err);
    idle(5);
    check("tmo_no_reply", tx_log.size(), n0);
    send_frame(8'h18, 8'h0F, 8'h17);
    check("tmo_next_we", {sid_we, sid_addr, sid_wdata}, {1'b1, 5'h18, 8'h0F});
    sid_ready = 1'b1;
    @(negedge clk);
    sid_ready = 1'b0;
    wait_tx(n0 + 1, 20);
    check("tmo_next_ack_cnt", tx_log.size(), n0 + 1);
    if (tx_log.size() > n0) check("tmo_next_ack", tx_log[n0], 8'h06);
    idle(10);

    // Overrun during ISSUE
    n0 = tx_log.size();
    send_frame(8'h01, 8'hAA, 8'hAB);
    send_byte(8'h77);
    exp_err++;
    check("ovr_err", err_cnt, exp_err);
    check("ovr_we_kept", {sid_we, sid_addr, sid_wdata}, {1'b1, 5'h01, 8'hAA});
    sid_ready = 1'b1;
    @(negedge clk);
    sid_ready = 1'b0;
    wait_tx(n0 + 1, 20);
    check("ovr_ack_cnt", tx_log.size(), n0 + 1);
    if (tx_log.size() > n0) check("ovr_ack", tx_log[n0], 8'h06);
    idle(10);

    // 0xA5 as DATA is data, not a resync
    send_frame(8'h03, 8'hA5, 8'hA6);
    check("a5_data_we", {sid_we, sid_addr, sid_wdata}, {1'b1, 5'h03, 8'hA5});
    sid_ready = 1'b1;
    @(negedge clk);
    sid_ready = 1'b0;
    idle(12);

    // Reset during GET_DATA
    n0 = tx_log.size();
    send_byte(8'hA5);
    send_byte(8'h05);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_vals("rst_getdata");
    @(negedge clk);
    rst = 1'b0;
    exp_err = 0;

    // Reset during ISSUE
    send_frame(8'h05, 8'h3C, 8'h39);
    check("rst_issue_pre_we", sid_we, 1'b1);
    rst = 1'b1;
    #1;
    check_reset_vals("rst_issue");
    @(negedge clk);
    rst = 1'b0;
    idle(3);
    check("rst_no_reply", tx_log.size(), n0);

    // Frame after reset, also seeds shadow[5] = 0x3C
    send_frame(8'h05, 8'h3C, 8'h39);
    check("post_rst_we", {sid_we, sid_addr, sid_wdata}, {1'b1, 5'h05, 8'h3C});
    sid_ready = 1'b1;
    @(negedge clk);
    sid_ready = 1'b0;
    wait_tx(n0 + 1, 20);
    check("post_rst_ack_cnt", tx_log.size(), n0 + 1);
    idle(10);

    // Ping: ACK, no SID access
    n0 = tx_log.size();
    send_frame(8'h20, 8'h00, 8'h20);
    check("ping_no_we", sid_we, 1'b0);
    wait_tx(n0 + 1, 20);
    check("ping_cnt", tx_log.size(), n0 + 1);
    if (tx_log.size() > n0) check("ping_ack", tx_log[n0], 8'h06);
    check("ping_err", err_cnt, exp_err);
    idle(10);

    // Readback of address 5
    n0 = tx_log.size();
    send_frame(8'h45, 8'h00, 8'h45);
`ifdef SID_CMD_READBACK_EN
    wait_tx(n0 + 2, 40);
    check("rd_cnt", tx_log.size(), n0 + 2);
    if (tx_log.size() > n0 + 1) begin
      check("rd_ack", tx_log[n0], 8'h06);
      check("rd_data", tx_log[n0 + 1], 8'h3C);
    end
`else
    exp_err++;
    check("rd_nak_start", tx_start, 1'b1);
    check("rd_nak", tx_data, 8'h15);
    idle(10);
    check("rd_cnt", tx_log.size(), n0 + 1);
`endif
    check("rd_err", err_cnt, exp_err);
    idle(10);

    // Bad opcode 111
    send_frame(8'hE0, 8'h11, 8'hF1);
    exp_err++;
    check("badop_nak", {tx_start, tx_data, sid_we}, {1'b1, 8'h15, 1'b0});
    check("badop_err", err_cnt, exp_err);
    idle(10);

    // Saturation at all-ones
    for (int i = 0; i < 8; i++) begin
      send_frame(8'h05, 8'h3C, 8'h00);
      idle(8);
    end
    check("err_saturate", err_cnt, 3'h7);

    check("tx_protocol_violations", viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
